// File: rtl/pixel_pkg.sv
// Shared state encoding and frame-size helper for the pixel feeder.
package pixel_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic int n_pix(input int h, input int w);
    return h * w;
  endfunction

endpackage

// File: rtl/pixel_feeder_frame_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// The array is never cleared; only the read register is reset.
module frame_ram #(
  parameter int ADDR_W = 4,
  parameter int PIX_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data
);

  logic [PIX_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // read register only updates on a fetch, so it stays stable while presented
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/pixel_feeder.sv
// Frame buffer that loads one frame from the host and serves it in raster order.
// Optional coordinate checker built when COORD_CHECK_EN is defined.
module pixel_feeder
  import pixel_pkg::*;
#(
  parameter int img_height = 4,
  parameter int img_width  = 4,
  parameter int PIX_W      = 8,
  parameter int ADDR_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [PIX_W-1:0] load_data,
  output logic             load_ready,
  output logic             data_pixel,
  output logic [PIX_W-1:0] pixel_out,
  input  logic             pixel_valid,
  input  logic [3:0]       x_in,
  input  logic [3:0]       y_in,
  output logic             busy,
  output logic             frame_done,
  output logic             coord_err
);

  localparam int N = n_pix(img_height, img_width);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_en;
  logic              rd_en;
  logic              accept;

  assign wr_en  = (state == EMPTY) && load_valid;
  assign rd_en  = (state == FETCH);
  assign accept = (state == PRESENT) && pixel_valid;

  frame_ram #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (load_data),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (pixel_out)
  );

  // load / fetch / present / done sequencing with registered flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      load_ready <= 1'b1;
      data_pixel <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (load_valid) begin
            if (wr_ptr == LAST) begin
              wr_ptr     <= '0;
              rd_ptr     <= '0;
              load_ready <= 1'b0;
              busy       <= 1'b1;
              state      <= FETCH;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        FETCH: begin
          data_pixel <= 1'b1;
          state      <= PRESENT;
        end
        PRESENT: begin
          if (pixel_valid) begin
            data_pixel <= 1'b0;
            if (rd_ptr == LAST) begin
              busy       <= 1'b0;
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
              state  <= FETCH;
            end
          end
        end
        DONE: begin
          frame_done <= 1'b0;
          load_ready <= 1'b1;
          state      <= EMPTY;
        end
        default: begin
          state      <= EMPTY;
          load_ready <= 1'b1;
          data_pixel <= 1'b0;
          busy       <= 1'b0;
          frame_done <= 1'b0;
        end
      endcase
    end
  end

`ifdef COORD_CHECK_EN
  logic [3:0] rd_x;
  logic [3:0] rd_y;

  // raster coordinates of rd_ptr and the sticky mismatch flag
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_x      <= 4'd0;
      rd_y      <= 4'd0;
      coord_err <= 1'b0;
    end else begin
      if (wr_en && (wr_ptr == '0)) begin
        coord_err <= 1'b0;
      end else if (accept && ({y_in, x_in} != {rd_y, rd_x})) begin
        coord_err <= 1'b1;
      end
      if (wr_en && (wr_ptr == LAST)) begin
        rd_x <= 4'd0;
        rd_y <= 4'd0;
      end else if (accept && (rd_ptr != LAST)) begin
        if (rd_x == 4'(img_width - 1)) begin
          rd_x <= 4'd0;
          rd_y <= rd_y + 4'd1;
        end else begin
          rd_x <= rd_x + 4'd1;
        end
      end
    end
  end
`else
  logic unused_coord;
  assign unused_coord = ^{x_in, y_in};
  assign coord_err    = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_feeder.sv
// Randomized self-checking bench for pixel_feeder against a frame-level reference model.
module tb_pixel_feeder;

  localparam int H  = 4;
  localparam int W  = 4;
  localparam int PW = 8;
  localparam int AW = 4;
  localparam int N  = H * W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_valid = 1'b0;
  logic [PW-1:0] load_data = '0;
  logic          load_ready;
  logic          data_pixel;
  logic [PW-1:0] pixel_out;
  logic          pixel_valid = 1'b0;
  logic [3:0]    x_in = 4'd0;
  logic [3:0]    y_in = 4'd0;
  logic          busy;
  logic          frame_done;
  logic          coord_err;

  int            checks = 0;
  int            errors = 0;
  logic [PW-1:0] frame [N];
  logic          exp_err = 1'b0;

  pixel_feeder #(.img_height(H), .img_width(W), .PIX_W(PW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .data_pixel(data_pixel), .pixel_out(pixel_out),
    .pixel_valid(pixel_valid), .x_in(x_in), .y_in(y_in), .busy(busy),
    .frame_done(frame_done), .coord_err(coord_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame();
    int gap;
    for (int i = 0; i < N; i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        load_valid = 1'b0;
        load_data  = PW'($urandom);
        step();
        check("gap_ready", load_ready, 1);
      end
      load_valid = 1'b1;
      load_data  = frame[i];
      step();
      if (i == 0) exp_err = 1'b0;
      check("load_cerr", coord_err, exp_err);
      if (i < N - 1) check("ready_mid", load_ready, 1);
    end
    check("ready_after_last", load_ready, 0);
    check("busy_fetch", busy, 1);
    check("dp_fetch", data_pixel, 0);
    load_valid  = 1'b1;
    load_data   = 8'hFF;
    pixel_valid = 1'($urandom_range(0, 1));
    step();
    pixel_valid = 1'b0;
    check("dp_first", data_pixel, 1);
    check("pix_first", pixel_out, frame[0]);
  endtask

  task automatic serve(input int bad_idx, input int stall_idx, input int stall_len, input int stop_after);
    int stall;
    for (int i = 0; i < N && i < stop_after; i++) begin
      check("dp", data_pixel, 1);
      check("pix", pixel_out, frame[i]);
      check("busy", busy, 1);
      check("cerr", coord_err, exp_err);
      stall = (i == stall_idx) ? stall_len : int'($urandom_range(0, 2));
      for (int k = 0; k < stall; k++) begin
        pixel_valid = 1'b0;
        load_valid  = 1'b1;
        load_data   = 8'hFF;
        step();
        check("stall_dp", data_pixel, 1);
        check("stall_pix", pixel_out, frame[i]);
      end
      pixel_valid = 1'b1;
      x_in = 4'(i % W);
      y_in = 4'(i / W);
      if (i == bad_idx) x_in = x_in - 4'd1;
      load_valid = 1'($urandom_range(0, 1));
      load_data  = 8'hFF;
      step();
      pixel_valid = 1'b0;
      x_in = 4'($urandom);
      y_in = 4'($urandom);
`ifdef COORD_CHECK_EN
      if (i == bad_idx) exp_err = 1'b1;
`endif
      check("cerr_acc", coord_err, exp_err);
      if (i == N - 1) begin
        check("fd_pulse", frame_done, 1);
        check("busy_done", busy, 0);
        check("dp_done", data_pixel, 0);
        check("ready_done", load_ready, 0);
        step();
        check("fd_clear", frame_done, 0);
        check("ready_back", load_ready, 1);
        check("busy_idle", busy, 0);
      end else begin
        check("dp_gap", data_pixel, 0);
        check("fd_quiet", frame_done, 0);
        pixel_valid = 1'($urandom_range(0, 1));
        step();
        pixel_valid = 1'b0;
      end
    end
    load_valid = 1'b0;
  endtask

  initial begin
    step();
    step();
    check("rst_ready", load_ready, 1);
    check("rst_dp", data_pixel, 0);
    check("rst_busy", busy, 0);
    check("rst_fd", frame_done, 0);
    check("rst_pix", pixel_out, 0);
    check("rst_cerr", coord_err, 0);
    reset = 1'b0;

    // ramp frame with long stall at pixel 5 and host noise during serve
    for (int i = 0; i < N; i++) frame[i] = PW'(i);
    load_frame();
    serve(-1, 5, 10, N);

    // random frame with a bad coordinate at pixel 3
    for (int i = 0; i < N; i++) frame[i] = PW'($urandom);
    load_frame();
    serve(3, -1, 0, N);
    check("cerr_sticky", coord_err, exp_err);

    // random frame interrupted by reset after accept 7
    for (int i = 0; i < N; i++) frame[i] = PW'($urandom);
    load_frame();
    serve(-1, -1, 0, 7);
    reset = 1'b1;
    step();
    exp_err = 1'b0;
    check("mid_rst_ready", load_ready, 1);
    check("mid_rst_dp", data_pixel, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cerr", coord_err, 0);
    reset = 1'b0;

    // fresh frame must start at address 0 and read back intact
    for (int i = 0; i < N; i++) frame[i] = PW'(i);
    load_frame();
    serve(-1, -1, 0, N);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
